hub75_rx: RTL and testbench
===========================

Name: hub75_rx

Overview:
- Receive-side counterpart of the HUB75 panel driver: samples a HUB75 output bus (O_CLK, STB, OE, A–E, R1/G1/B1, R2/G2/B2) and rebuilds full-depth RGB pixels from the serial bit-plane stream.
- Emits the rebuilt pixels on a frame-buffer-style write port ({R,G,B}, packed address).
- Used as a loopback checker for the display path and as the input stage of a chained panel.
- All HUB75 inputs are asynchronous to clk and are oversampled.

Parameters:
- hpixel_p, 64, display width in pixels (columns per shifted line)
- vpixel_p, 64, display height in pixels
- bpp_p, 8, bits per colour channel (bit-planes per row)
- segments_p, 2, display segments; segment s carries rows s*(vpixel_p/segments_p)+row
- (local) row_w_p = $clog2(vpixel_p/segments_p); addr_width_p = $clog2(hpixel_p*vpixel_p)

Ports:
- clk  in  1  system clock; must be at least 4x the HUB75 O_CLK rate
- rst_n  in  1  asynchronous active-low reset
- i_enable  in  1  receiver enable
- i_err_clr  in  1  single-cycle pulse; clears all sticky error flags
- i_hub_clk  in  1  HUB75 O_CLK
- i_hub_stb  in  1  HUB75 STB (latch)
- i_hub_oe  in  1  HUB75 OE; synchronised but ignored for data recovery
- i_hub_row  in  row_w_p  {E,D,C,B,A}
- i_hub_rgb  in  6  {B2,G2,R2,B1,G1,R1}
- o_wr_addr  out  addr_width_p  pixel address: row*hpixel_p + col
- o_wr_data  out  3*bpp_p  pixel data packed {R,G,B}
- o_wr_valid  out  1  write request
- i_wr_ready  in  1  sink accepts the write when valid&ready
- o_err_cols  out  1  sticky: STB seen with column count != hpixel_p
- o_err_seq  out  1  sticky: row address changed before all bpp_p planes were received
- o_err_ovr  out  1  sticky: STB arrived while S_EMIT was active

Behaviour:
- Reset values: all outputs 0; FSM in S_IDLE; plane_idx = bpp_p-1; col_cnt = 0.
- Input conditioning:
  - All HUB75 inputs pass through a 2-FF synchroniser, then one edge-detect register.
  - clk_rise / stb_rise are single-cycle pulses; data sampling latency is 3 clk cycles.
- Shift stage, on clk_rise:
  - Synchronised i_hub_rgb is written into line register slot col_cnt; col_cnt increments.
  - col_cnt saturates at hpixel_p; bits beyond that are discarded.
  - Line register holds hpixel_p x 6 bits.
- Latch stage, on stb_rise:
  - If col_cnt != hpixel_p, set o_err_cols.
  - Copy line bits into the accumulator at bit position plane_idx for every pixel, both segments (accumulator holds segments_p x hpixel_p x 3 x bpp_p bits).
  - Clear col_cnt.
  - Planes arrive MSB first: the first STB for a row is bit bpp_p-1.
- Simultaneous clk_rise and stb_rise in the same cycle: shift first, then latch; that column counts.
- Row tracking: the row is captured on the first plane (plane_idx == bpp_p-1).
  - A later plane with a different row: set o_err_seq, discard the partial accumulator, restart at bpp_p-1 with the new row.
- FSM:
  - S_IDLE -> S_COLLECT when i_enable = 1.
  - S_COLLECT -> S_EMIT on the stb_rise that latches plane 0; plane_idx resets to bpp_p-1.
  - S_EMIT: one write per valid&ready handshake.
    - Order: segment 0 col 0..hpixel_p-1, then segment 1, and so on.
    - Address = (seg*(vpixel_p/segments_p)+row)*hpixel_p + col.
  - After the last accepted write -> S_COLLECT.
- Emit timing: o_wr_valid rises the cycle after the final latch.
- Handshake: o_wr_addr/o_wr_data are held stable while valid & !ready; throughput is 1 pixel/clk when ready is held high.
- During S_EMIT:
  - Shifting continues into the line register.
  - stb_rise sets o_err_ovr and drops that plane; plane_idx is unchanged.
- i_enable = 0 (any state): next cycle go to S_IDLE; valid drops immediately, even mid-burst; counters reset; accumulator content is don't-care.
- Error flags: sticky; cleared only by i_err_clr or reset. If i_err_clr coincides with a new error event, the set wins.

Optional Feature:
- Macro: HUB75_RX_STATS_EN.
- Defined:
  - Adds output o_frame_cnt (16 bit, reset 0), incrementing when the last pixel of row (vpixel_p/segments_p - 1) is accepted; wraps at 0xFFFF -> 0.
  - Adds output o_row_done (1-cycle pulse) per completed row burst.
- Undefined: neither port exists; no counter logic.

Test Plan:
- Reset mid-burst: assert rst_n = 0 during S_EMIT -> all outputs 0 immediately; after release, no write until a full new 8-plane row is received.
- Nominal row: defaults, row 5, 8 planes encoding pixel col 3 seg0 = {R=0xA5,G=0x3C,B=0xFF}, seg1 = {0x01,0x80,0x00}, i_wr_ready = 1 -> 128 consecutive writes; addr 323 = 0xA53CFF, addr 2371 = 0x018000; o_wr_valid high exactly 128 cycles.
- Backpressure: i_wr_ready toggling 1/0 each cycle during emit -> 128 writes over 256 cycles; addr/data stable while stalled; no duplicate or missing address.
- Short line: 63 O_CLK pulses then STB -> o_err_cols = 1; i_err_clr pulse -> 0.
- Sequence error: row changes from 5 to 6 after 3 planes -> o_err_seq = 1, no writes for row 5; row 6 completes normally.
- Overrun plus coincident edges: STB during emit with ready = 0 -> o_err_ovr = 1, plane dropped. O_CLK and STB edges landing in the same sampled cycle -> column 63 retained, o_err_cols stays 0.

Source files
------------

// File: rtl/hub75_rx_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hub75_rx_if : pixel write port of the HUB75 receiver                 |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
interface hub75_rx_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 24
);
    logic [ADDR_W-1:0] o_wr_addr;
    logic [DATA_W-1:0] o_wr_data;
    logic              o_wr_valid;
    logic              i_wr_ready;

    modport master (output o_wr_addr, output o_wr_data, output o_wr_valid, input i_wr_ready);
    modport slave  (input o_wr_addr, input o_wr_data, input o_wr_valid, output i_wr_ready);
endinterface
`default_nettype wire

// File: rtl/hub75_rx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hub75_rx : oversampling HUB75 receiver, rebuilds RGB pixels from the |
// | bit-plane stream. Optional stats via HUB75_RX_STATS_EN.              |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module hub75_rx #(
    parameter int HPIXEL_P   = 64,
    parameter int VPIXEL_P   = 64,
    parameter int BPP_P      = 8,
    parameter int SEGMENTS_P = 2,
    localparam int c_row_w   = $clog2(VPIXEL_P / SEGMENTS_P),
    localparam int c_addr_w  = $clog2(HPIXEL_P * VPIXEL_P)
) (
    input  wire               clk,
    input  wire               rst_n,
    input  wire               i_enable,
    input  wire               i_err_clr,
    input  wire               i_hub_clk,
    input  wire               i_hub_stb,
    input  wire               i_hub_oe,
    input  wire [c_row_w-1:0] i_hub_row,
    input  wire [5:0]         i_hub_rgb,
    hub75_rx_if.master        wr,
    output logic              o_err_cols,
    output logic              o_err_seq,
    output logic              o_err_ovr
`ifdef HUB75_RX_STATS_EN
   ,output logic [15:0]       o_frame_cnt,
    output logic              o_row_done
`endif
);

    localparam int c_rps     = VPIXEL_P / SEGMENTS_P;
    localparam int c_data_w  = 3 * BPP_P;
    localparam int c_cnt_w   = $clog2(HPIXEL_P + 1);
    localparam int c_col_w   = (HPIXEL_P > 1) ? $clog2(HPIXEL_P) : 1;
    localparam int c_seg_w   = (SEGMENTS_P > 1) ? $clog2(SEGMENTS_P) : 1;
    localparam int c_plane_w = (BPP_P > 1) ? $clog2(BPP_P) : 1;
    localparam int c_sync_w  = c_row_w + 8;

    localparam logic [c_cnt_w-1:0]   c_cols_full = c_cnt_w'(HPIXEL_P);
    localparam logic [c_col_w-1:0]   c_col_last  = c_col_w'(HPIXEL_P - 1);
    localparam logic [c_seg_w-1:0]   c_seg_last  = c_seg_w'(SEGMENTS_P - 1);
    localparam logic [c_plane_w-1:0] c_plane_top = c_plane_w'(BPP_P - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_EMIT    = 2'd2
    } state_t;

    state_t                r_state, w_state_next;
    logic [c_sync_w-1:0]   r_sync1, r_sync2;
    logic                  r_clk_d, r_stb_d;
    logic                  r_oe_meta, r_oe_sync_unused;
    logic [c_cnt_w-1:0]    r_col_cnt;
    logic [c_plane_w-1:0]  r_plane;
    logic [c_row_w-1:0]    r_row;
    logic [c_col_w-1:0]    r_emit_col;
    logic [c_seg_w-1:0]    r_seg;
    logic                  r_err_cols, r_err_seq, r_err_ovr;
    logic [5:0]            r_line     [HPIXEL_P];
    logic [5:0]            w_line_eff [HPIXEL_P];
    logic [c_data_w-1:0]   r_acc      [SEGMENTS_P][HPIXEL_P];

    logic [5:0]            w_rgb;
    logic [c_row_w-1:0]    w_row;
    logic                  w_clk_rise, w_stb_rise, w_active, w_shift, w_latch;
    logic                  w_first, w_seq_err, w_last_plane, w_valid, w_hs, w_burst_done;
    logic [c_cnt_w-1:0]    w_cols_now;
    logic [c_plane_w-1:0]  w_plane_tgt;
    logic [c_addr_w-1:0]   w_line_idx, w_addr;

    // 2-FF synchroniser followed by one edge-detect stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1          <= '0;
            r_sync2          <= '0;
            r_clk_d          <= 1'b0;
            r_stb_d          <= 1'b0;
            r_oe_meta        <= 1'b0;
            r_oe_sync_unused <= 1'b0;
        end else begin
            r_sync1          <= {i_hub_row, i_hub_rgb, i_hub_stb, i_hub_clk};
            r_sync2          <= r_sync1;
            r_clk_d          <= r_sync2[0];
            r_stb_d          <= r_sync2[1];
            r_oe_meta        <= i_hub_oe;
            r_oe_sync_unused <= r_oe_meta;
        end
    end

    assign w_rgb      = r_sync2[7:2];
    assign w_row      = r_sync2[c_sync_w-1:8];
    assign w_clk_rise = r_sync2[0] & ~r_clk_d;
    assign w_stb_rise = r_sync2[1] & ~r_stb_d;

    assign w_active     = i_enable && (r_state != S_IDLE);
    assign w_shift      = w_active && w_clk_rise && (r_col_cnt != c_cols_full);
    assign w_cols_now   = w_shift ? r_col_cnt + c_cnt_w'(1) : r_col_cnt;
    assign w_latch      = w_active && w_stb_rise && (r_state == S_COLLECT);
    assign w_first      = (r_plane == c_plane_top);
    assign w_seq_err    = w_latch && !w_first && (w_row != r_row);
    // A row change restarts collection; the current plane becomes the new row's MSB
    assign w_plane_tgt  = w_seq_err ? c_plane_top : r_plane;
    assign w_last_plane = w_latch && (w_plane_tgt == '0);
    assign w_hs         = w_valid && wr.i_wr_ready;
    assign w_burst_done = w_hs && (r_emit_col == c_col_last) && (r_seg == c_seg_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_valid      = 1'b0;
        case (r_state)
            S_IDLE:    if (i_enable) w_state_next = S_COLLECT;
            S_COLLECT: if (w_last_plane) w_state_next = S_EMIT;
            S_EMIT: begin
                w_valid = 1'b1;
                if (w_burst_done) w_state_next = S_COLLECT;
            end
            default:   w_state_next = S_IDLE;
        endcase
        if (!i_enable) begin
            w_state_next = S_IDLE;
            w_valid      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col_cnt  <= '0;
            r_plane    <= c_plane_top;
            r_row      <= '0;
            r_emit_col <= '0;
            r_seg      <= '0;
            r_err_cols <= 1'b0;
            r_err_seq  <= 1'b0;
            r_err_ovr  <= 1'b0;
        end else begin
            if (w_active && w_stb_rise && (w_cols_now != c_cols_full)) r_err_cols <= 1'b1;
            else if (i_err_clr)                                        r_err_cols <= 1'b0;
            if (w_seq_err)      r_err_seq <= 1'b1;
            else if (i_err_clr) r_err_seq <= 1'b0;
            if (w_active && w_stb_rise && (r_state == S_EMIT)) r_err_ovr <= 1'b1;
            else if (i_err_clr)                                r_err_ovr <= 1'b0;

            if (!w_active) begin
                r_col_cnt  <= '0;
                r_plane    <= c_plane_top;
                r_emit_col <= '0;
                r_seg      <= '0;
            end else begin
                if (w_stb_rise)   r_col_cnt <= '0;
                else if (w_shift) r_col_cnt <= r_col_cnt + c_cnt_w'(1);

                if (w_latch) begin
                    if (w_first || w_seq_err) r_row <= w_row;
                    r_plane <= (w_plane_tgt == '0) ? c_plane_top : w_plane_tgt - c_plane_w'(1);
                end

                if (w_hs) begin
                    if (r_emit_col == c_col_last) begin
                        r_emit_col <= '0;
                        r_seg      <= (r_seg == c_seg_last) ? '0 : r_seg + c_seg_w'(1);
                    end else begin
                        r_emit_col <= r_emit_col + c_col_w'(1);
                    end
                end
            end
        end
    end

    // Line as seen after this cycle's shift, so a coincident STB keeps the new column
    always_comb begin
        for (int c = 0; c < HPIXEL_P; c++) begin
            w_line_eff[c] = (w_shift && (r_col_cnt == c_cnt_w'(c))) ? w_rgb : r_line[c];
        end
    end

    always_ff @(posedge clk) begin
        for (int c = 0; c < HPIXEL_P; c++) begin
            r_line[c] <= w_line_eff[c];
        end
        if (w_latch) begin
            for (int s = 0; s < SEGMENTS_P; s++) begin
                for (int c = 0; c < HPIXEL_P; c++) begin
                    for (int b = 0; b < BPP_P; b++) begin
                        if (w_plane_tgt == c_plane_w'(b)) begin
                            r_acc[s][c][2*BPP_P+b] <= w_line_eff[c][3*s];
                            r_acc[s][c][BPP_P+b]   <= w_line_eff[c][3*s+1];
                            r_acc[s][c][b]         <= w_line_eff[c][3*s+2];
                        end
                    end
                end
            end
        end
    end

    assign w_line_idx    = c_addr_w'(r_seg) * c_addr_w'(c_rps) + c_addr_w'(r_row);
    assign w_addr        = w_line_idx * c_addr_w'(HPIXEL_P) + c_addr_w'(r_emit_col);
    assign wr.o_wr_valid = w_valid;
    assign wr.o_wr_addr  = w_valid ? w_addr : '0;
    assign wr.o_wr_data  = w_valid ? r_acc[r_seg][r_emit_col] : '0;
    assign o_err_cols    = r_err_cols;
    assign o_err_seq     = r_err_seq;
    assign o_err_ovr     = r_err_ovr;

`ifdef HUB75_RX_STATS_EN
    localparam logic [c_row_w-1:0] c_row_last = c_row_w'(c_rps - 1);
    logic [15:0] r_frame_cnt;
    logic        r_row_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_cnt <= '0;
            r_row_done  <= 1'b0;
        end else begin
            r_row_done <= w_burst_done;
            if (w_burst_done && (r_row == c_row_last)) r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    assign o_frame_cnt = r_frame_cnt;
    assign o_row_done  = r_row_done;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hub75_rx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_hub75_rx : directed self-checking bench for hub75_rx              |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module tb_hub75_rx;
    localparam int H = 64, V = 64, B = 8, S = 2, RPS = 32, AW = 12, DW = 24;

    logic       clk = 1'b0, rst_n = 1'b0, i_enable = 1'b0, i_err_clr = 1'b0;
    logic       hub_clk = 1'b0, hub_stb = 1'b0, hub_oe = 1'b0;
    logic [4:0] hub_row = '0;
    logic [5:0] hub_rgb = '0;
    logic       err_cols, err_seq, err_ovr;
`ifdef HUB75_RX_STATS_EN
    logic [15:0] frame_cnt;
    logic        row_done;
`endif

    int tests = 0, fails = 0;
    int n_wr = 0, vcyc = 0, stall_viol = 0, mode = 0, tog_base = 0;
    logic          prev_stall = 1'b0;
    logic [AW-1:0] prev_addr = '0;
    logic [DW-1:0] prev_data = '0;
    logic [AW-1:0] rec_addr [1024];
    logic [DW-1:0] rec_data [1024];

    hub75_rx_if #(.ADDR_W(AW), .DATA_W(DW)) wr_if ();

    hub75_rx #(.HPIXEL_P(H), .VPIXEL_P(V), .BPP_P(B), .SEGMENTS_P(S)) u_dut (
        .clk(clk), .rst_n(rst_n), .i_enable(i_enable), .i_err_clr(i_err_clr),
        .i_hub_clk(hub_clk), .i_hub_stb(hub_stb), .i_hub_oe(hub_oe),
        .i_hub_row(hub_row), .i_hub_rgb(hub_rgb), .wr(wr_if),
        .o_err_cols(err_cols), .o_err_seq(err_seq), .o_err_ovr(err_ovr)
`ifdef HUB75_RX_STATS_EN
       ,.o_frame_cnt(frame_cnt), .o_row_done(row_done)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Sink model: drives ready per mode, records accepted writes, watches stall stability
    always @(negedge clk) begin
        logic rdy;
        if (wr_if.o_wr_valid) begin
            vcyc++;
            if (prev_stall && (wr_if.o_wr_addr !== prev_addr || wr_if.o_wr_data !== prev_data))
                stall_viol++;
        end
        case (mode)
            0:       rdy = 1'b1;
            1:       rdy = ((vcyc - tog_base) % 2 == 0);
            default: rdy = 1'b0;
        endcase
        wr_if.i_wr_ready = rdy;
        if (wr_if.o_wr_valid && rdy) begin
            rec_addr[n_wr % 1024] = wr_if.o_wr_addr;
            rec_data[n_wr % 1024] = wr_if.o_wr_data;
            n_wr++;
        end
        prev_stall = wr_if.o_wr_valid && !rdy;
        prev_addr  = wr_if.o_wr_addr;
        prev_data  = wr_if.o_wr_data;
    end

    function automatic logic [23:0] exp_pix(input int seg, input int col);
        logic [7:0] r, g, b;
        if (col == 3) return (seg == 0) ? 24'hA53CFF : 24'h018000;
        r = 8'(col * 5 + seg * 17);
        g = 8'(col) ^ ((seg == 0) ? 8'h5A : 8'hA5);
        b = 8'(255 - col - seg * 3);
        return {r, g, b};
    endfunction

    function automatic logic [5:0] plane_bits(input int col, input int p);
        logic [23:0] e0, e1;
        e0 = exp_pix(0, col);
        e1 = exp_pix(1, col);
        return {e1[p], e1[8+p], e1[16+p], e0[p], e0[8+p], e0[16+p]};
    endfunction

    function automatic int seq_errors(input int base, input int row);
        int e = 0;
        for (int i = 0; i < 2 * H; i++) begin
            int seg, col, idx;
            seg = i / H;
            col = i % H;
            idx = (base + i) % 1024;
            if (rec_addr[idx] !== AW'((seg * RPS + row) * H + col) || rec_data[idx] !== exp_pix(seg, col))
                e++;
        end
        return e;
    endfunction

    task automatic hub_col(input logic [5:0] d, input bit with_stb);
        @(negedge clk);
        hub_clk = 1'b0;
        hub_rgb = d;
        repeat (2) @(negedge clk);
        hub_clk = 1'b1;
        if (with_stb) hub_stb = 1'b1;
        repeat (2) @(negedge clk);
        hub_clk = 1'b0;
        hub_stb = 1'b0;
    endtask

    task automatic send_plane(input int row, input int p, input int ncols, input bit coincide);
        hub_row = 5'(row);
        for (int c = 0; c < ncols; c++) hub_col(plane_bits(c, p), coincide && (c == ncols - 1));
        if (!coincide) begin
            @(negedge clk);
            hub_stb = 1'b1;
            repeat (2) @(negedge clk);
            hub_stb = 1'b0;
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic send_row(input int row, input int p_hi, input int p_lo);
        for (int p = p_hi; p >= p_lo; p--) send_plane(row, p, H, 1'b0);
    endtask

    task automatic wait_writes(input int base, input int target);
        int k = 0;
        while ((n_wr - base) < target && k < 3000) begin
            @(negedge clk);
            k++;
        end
        repeat (5) @(negedge clk);
    endtask

    task automatic wait_valid();
        int k = 0;
        while (!wr_if.o_wr_valid && k < 3000) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic restart();
        @(negedge clk);
        i_enable = 1'b0;
        repeat (3) @(negedge clk);
        i_enable = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        i_err_clr = 1'b1;
        @(negedge clk);
        i_err_clr = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        tests++;
        if ({wr_if.o_wr_valid, wr_if.o_wr_addr, wr_if.o_wr_data} !== '0) begin
            fails++;
            $display("FAIL reset_wr: got v=%b a=%0h d=%0h expected all 0", wr_if.o_wr_valid, wr_if.o_wr_addr, wr_if.o_wr_data);
        end
        tests++;
        if ({err_cols, err_seq, err_ovr} !== 3'b000) begin
            fails++;
            $display("FAIL reset_err: got %b expected 000", {err_cols, err_seq, err_ovr});
        end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        i_enable = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_nominal();
        int b0 = n_wr, v0 = vcyc;
        mode = 0;
        send_row(5, 7, 0);
        wait_writes(b0, 128);
        tests++;
        if (n_wr - b0 !== 128) begin fails++; $display("FAIL nominal_count: got %0d expected 128", n_wr - b0); end
        tests++;
        if (vcyc - v0 !== 128) begin fails++; $display("FAIL nominal_valid_cycles: got %0d expected 128", vcyc - v0); end
        tests++;
        if (seq_errors(b0, 5) !== 0) begin fails++; $display("FAIL nominal_seq: got %0d bad writes expected 0", seq_errors(b0, 5)); end
        tests++;
        if (rec_addr[(b0+3)%1024] !== 12'd323 || rec_data[(b0+3)%1024] !== 24'hA53CFF) begin
            fails++;
            $display("FAIL nominal_pix323: got a=%0d d=%h expected a=323 d=a53cff", rec_addr[(b0+3)%1024], rec_data[(b0+3)%1024]);
        end
        tests++;
        if (rec_addr[(b0+67)%1024] !== 12'd2371 || rec_data[(b0+67)%1024] !== 24'h018000) begin
            fails++;
            $display("FAIL nominal_pix2371: got a=%0d d=%h expected a=2371 d=018000", rec_addr[(b0+67)%1024], rec_data[(b0+67)%1024]);
        end
        tests++;
        if ({err_cols, err_seq, err_ovr} !== 3'b000) begin fails++; $display("FAIL nominal_err: got %b expected 000", {err_cols, err_seq, err_ovr}); end
    endtask

    task automatic test_backpressure();
        int b0 = n_wr, v0 = vcyc, s0 = stall_viol;
        tog_base = vcyc;
        mode = 1;
        send_row(9, 7, 0);
        wait_writes(b0, 128);
        mode = 0;
        tests++;
        if (n_wr - b0 !== 128) begin fails++; $display("FAIL bp_count: got %0d expected 128", n_wr - b0); end
        tests++;
        if (vcyc - v0 !== 256) begin fails++; $display("FAIL bp_valid_cycles: got %0d expected 256", vcyc - v0); end
        tests++;
        if (stall_viol - s0 !== 0) begin fails++; $display("FAIL bp_stable: got %0d changes while stalled expected 0", stall_viol - s0); end
        tests++;
        if (seq_errors(b0, 9) !== 0) begin fails++; $display("FAIL bp_seq: got %0d bad writes expected 0", seq_errors(b0, 9)); end
    endtask

    task automatic test_short_line();
        send_plane(5, 7, 63, 1'b0);
        tests++;
        if (err_cols !== 1'b1) begin fails++; $display("FAIL short_err_cols: got %b expected 1", err_cols); end
        pulse_clr();
        tests++;
        if (err_cols !== 1'b0) begin fails++; $display("FAIL short_err_clr: got %b expected 0", err_cols); end
        restart();
    endtask

    task automatic test_seq();
        int b0 = n_wr;
        send_row(5, 7, 5);
        tests++;
        if (n_wr - b0 !== 0 || err_seq !== 1'b0) begin
            fails++;
            $display("FAIL seq_before: got writes=%0d err_seq=%b expected 0/0", n_wr - b0, err_seq);
        end
        send_row(6, 7, 0);
        wait_writes(b0, 128);
        tests++;
        if (err_seq !== 1'b1) begin fails++; $display("FAIL seq_flag: got %b expected 1", err_seq); end
        tests++;
        if (n_wr - b0 !== 128) begin fails++; $display("FAIL seq_count: got %0d expected 128", n_wr - b0); end
        tests++;
        if (seq_errors(b0, 6) !== 0) begin fails++; $display("FAIL seq_row6: got %0d bad writes expected 0", seq_errors(b0, 6)); end
        pulse_clr();
        tests++;
        if (err_seq !== 1'b0) begin fails++; $display("FAIL seq_clr: got %b expected 0", err_seq); end
    endtask

    task automatic test_overrun();
        int b0 = n_wr, b1;
        mode = 2;
        send_row(7, 7, 0);
        wait_valid();
        tests++;
        if (wr_if.o_wr_valid !== 1'b1 || n_wr - b0 !== 0) begin
            fails++;
            $display("FAIL ovr_stall: got v=%b writes=%0d expected 1/0", wr_if.o_wr_valid, n_wr - b0);
        end
        send_plane(7, 7, H, 1'b0);
        tests++;
        if (err_ovr !== 1'b1 || err_cols !== 1'b0) begin
            fails++;
            $display("FAIL ovr_flag: got ovr=%b cols=%b expected 1/0", err_ovr, err_cols);
        end
        mode = 0;
        wait_writes(b0, 128);
        tests++;
        if (n_wr - b0 !== 128 || seq_errors(b0, 7) !== 0) begin
            fails++;
            $display("FAIL ovr_drain: got writes=%0d bad=%0d expected 128/0", n_wr - b0, seq_errors(b0, 7));
        end
        b1 = n_wr;
        send_row(8, 7, 1);
        repeat (20) @(negedge clk);
        tests++;
        if (n_wr - b1 !== 0) begin fails++; $display("FAIL ovr_dropped: got %0d early writes expected 0", n_wr - b1); end
        send_row(8, 0, 0);
        wait_writes(b1, 128);
        tests++;
        if (n_wr - b1 !== 128 || seq_errors(b1, 8) !== 0) begin
            fails++;
            $display("FAIL ovr_next_row: got writes=%0d bad=%0d expected 128/0", n_wr - b1, seq_errors(b1, 8));
        end
    endtask

    task automatic test_coincident();
        int b0 = n_wr;
        for (int p = 7; p >= 0; p--) send_plane(10, p, H, 1'b1);
        wait_writes(b0, 128);
        tests++;
        if (err_cols !== 1'b0) begin fails++; $display("FAIL coin_err_cols: got %b expected 0", err_cols); end
        tests++;
        if (rec_data[(b0+63)%1024] !== exp_pix(0, 63) || rec_data[(b0+127)%1024] !== exp_pix(1, 63)) begin
            fails++;
            $display("FAIL coin_col63: got %h/%h expected %h/%h", rec_data[(b0+63)%1024], rec_data[(b0+127)%1024], exp_pix(0, 63), exp_pix(1, 63));
        end
        tests++;
        if (n_wr - b0 !== 128 || seq_errors(b0, 10) !== 0) begin
            fails++;
            $display("FAIL coin_row: got writes=%0d bad=%0d expected 128/0", n_wr - b0, seq_errors(b0, 10));
        end
    endtask

    task automatic test_reset_mid_burst();
        int b0;
        mode = 2;
        send_row(11, 7, 0);
        wait_valid();
        tests++;
        if (err_ovr !== 1'b1 || wr_if.o_wr_valid !== 1'b1) begin
            fails++;
            $display("FAIL rst_pre: got ovr=%b v=%b expected 1/1", err_ovr, wr_if.o_wr_valid);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests++;
        if ({wr_if.o_wr_valid, wr_if.o_wr_addr, wr_if.o_wr_data, err_cols, err_seq, err_ovr} !== '0) begin
            fails++;
            $display("FAIL rst_outputs: got v=%b a=%0h d=%0h err=%b expected all 0", wr_if.o_wr_valid, wr_if.o_wr_addr, wr_if.o_wr_data, {err_cols, err_seq, err_ovr});
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        mode = 0;
        b0 = n_wr;
        repeat (20) @(negedge clk);
        send_row(12, 7, 1);
        tests++;
        if (n_wr - b0 !== 0) begin fails++; $display("FAIL rst_no_write: got %0d writes expected 0", n_wr - b0); end
        send_row(12, 0, 0);
        wait_writes(b0, 128);
        tests++;
        if (n_wr - b0 !== 128 || seq_errors(b0, 12) !== 0) begin
            fails++;
            $display("FAIL rst_new_row: got writes=%0d bad=%0d expected 128/0", n_wr - b0, seq_errors(b0, 12));
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_backpressure();
        test_short_line();
        test_seq();
        test_overrun();
        test_coincident();
        test_reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire
